// File: rtl/muldiv_sched_pkg.sv
// Shared ALU op codes and scheduler state encodings for the MUL/DIV scheduler.
package muldiv_sched_pkg;
  localparam int XLEN         = 32;
  localparam int ALU_OP_WIDTH = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP    = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 5'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 5'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 5'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 5'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 5'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 5'd15;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 5'd16;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {MDS_IDLE, MDS_MUL, MDS_DIV, MDS_PEND} mds_state_e;

  function automatic logic is_mul(input logic [ALU_OP_WIDTH-1:0] op);
    return (op >= ALU_MUL) && (op <= ALU_MULHU);
  endfunction

  function automatic logic is_div(input logic [ALU_OP_WIDTH-1:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction
endpackage

// File: rtl/muldiv_pend_buf.sv
// One-entry holding register for the slot-1 op deferred behind slot 0.
module muldiv_pend_buf
  import muldiv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int OP_WIDTH   = ALU_OP_WIDTH,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [OP_WIDTH-1:0]   load_op,
  input  logic [DATA_WIDTH-1:0] load_s1,
  input  logic [DATA_WIDTH-1:0] load_s2,
  input  logic [RD_WIDTH-1:0]   load_rd,
  output logic                  valid,
  output logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] s1,
  output logic [DATA_WIDTH-1:0] s2,
  output logic [RD_WIDTH-1:0]   rd
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      op    <= '0;
      s1    <= '0;
      s2    <= '0;
      rd    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      op    <= load_op;
      s1    <= load_s1;
      s2    <= load_s2;
      rd    <= load_rd;
    end
  end
endmodule

// File: rtl/muldiv_sched.sv
// Arbitrates the shared multiplier / iterative divider between two EX slots,
// slot 0 first, holding ID/EX until every accepted op has produced its result.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int OP_WIDTH   = ALU_OP_WIDTH,
  parameter int RD_WIDTH   = 5,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_WIDTH-1:0]   req_op_0,
  input  logic [DATA_WIDTH-1:0] req_s1_0,
  input  logic [DATA_WIDTH-1:0] req_s2_0,
  input  logic [RD_WIDTH-1:0]   req_rd_0,
  input  logic [OP_WIDTH-1:0]   req_op_1,
  input  logic [DATA_WIDTH-1:0] req_s1_1,
  input  logic [DATA_WIDTH-1:0] req_s2_1,
  input  logic [RD_WIDTH-1:0]   req_rd_1,
  input  logic                  flush,
  output logic                  mul_start,
  output logic                  div_start,
  output logic [OP_WIDTH-1:0]   md_op,
  output logic [DATA_WIDTH-1:0] md_a,
  output logic [DATA_WIDTH-1:0] md_b,
  input  logic [DATA_WIDTH-1:0] mul_result,
  input  logic                  div_done,
  input  logic [DATA_WIDTH-1:0] div_result,
  output logic                  div_kill,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [RD_WIDTH-1:0]   res_rd,
  output logic                  res_slot,
  output logic                  md_stall
);
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  mds_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic [RD_WIDTH-1:0]   cur_rd;
  logic                  cur_slot;
  logic                  live;
  logic                  pend_v;
  logic [OP_WIDTH-1:0]   pend_op;
  logic [DATA_WIDTH-1:0] pend_s1, pend_s2;
  logic [RD_WIDTH-1:0]   pend_rd;

  logic                  md0, md1, launch, pend_load, pend_clr, res_fire, l_slot;
  logic [OP_WIDTH-1:0]   l_op;
  logic [DATA_WIDTH-1:0] l_s1, l_s2;
  logic [RD_WIDTH-1:0]   l_rd;

  assign md0 = is_mul(req_op_0) | is_div(req_op_0);
  assign md1 = is_mul(req_op_1) | is_div(req_op_1);

  // Launch source: slot 0 wins in IDLE; PEND replays the buffered slot-1 op.
  always_comb begin
    l_op   = req_op_0;
    l_s1   = req_s1_0;
    l_s2   = req_s2_0;
    l_rd   = req_rd_0;
    l_slot = 1'b0;
    launch = 1'b0;
    case (state)
      MDS_IDLE: begin
        launch = md0 | md1;
        if (!md0) begin
          l_op   = req_op_1;
          l_s1   = req_s1_1;
          l_s2   = req_s2_1;
          l_rd   = req_rd_1;
          l_slot = 1'b1;
        end
      end
      MDS_PEND: begin
        launch = 1'b1;
        l_op   = pend_op;
        l_s1   = pend_s1;
        l_s2   = pend_s2;
        l_rd   = pend_rd;
        l_slot = 1'b1;
      end
      default: ;
    endcase
    launch = launch & live & ~flush;
  end

  assign pend_load = launch & (state == MDS_IDLE) & md0 & md1;
  assign pend_clr  = flush | (launch & (state == MDS_PEND));
  assign res_fire  = ~flush & (((state == MDS_MUL) && (cnt == CNT_W'(MUL_LAT))) ||
                               ((state == MDS_DIV) && div_done));

  muldiv_pend_buf #(.DATA_WIDTH(DATA_WIDTH), .OP_WIDTH(OP_WIDTH), .RD_WIDTH(RD_WIDTH)) u_pend (
    .clk     (clk),
    .rst     (rst),
    .load    (pend_load),
    .clear   (pend_clr),
    .load_op (req_op_1),
    .load_s1 (req_s1_1),
    .load_s2 (req_s2_1),
    .load_rd (req_rd_1),
    .valid   (pend_v),
    .op      (pend_op),
    .s1      (pend_s1),
    .s2      (pend_s2),
    .rd      (pend_rd)
  );

  assign mul_start = launch & is_mul(l_op);
  assign div_start = launch & is_div(l_op);
  assign md_op     = launch ? l_op : '0;
  assign md_a      = launch ? l_s1 : '0;
  assign md_b      = launch ? l_s2 : '0;
  assign res_valid = res_fire;
  assign res_data  = !res_fire ? '0 : ((state == MDS_MUL) ? mul_result : div_result);
  assign res_rd    = res_fire ? cur_rd : '0;
  assign res_slot  = res_fire & cur_slot;

  // live stays low through reset and the rest of that cycle; div_kill holds the divider off.
  assign div_kill = ~live | (flush & ((state == MDS_DIV) ||
                                      ((state == MDS_PEND) && is_div(pend_op))));

  always_comb begin
    case (state)
      MDS_IDLE: md_stall = launch;
      MDS_PEND: md_stall = 1'b1;
      default:  md_stall = ~(res_fire & ~pend_v);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MDS_IDLE;
      cnt      <= '0;
      cur_rd   <= '0;
      cur_slot <= 1'b0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        state <= MDS_IDLE;
      end else begin
        case (state)
          MDS_IDLE, MDS_PEND: if (launch) begin
            state    <= is_mul(l_op) ? MDS_MUL : MDS_DIV;
            cnt      <= CNT_W'(1);
            cur_rd   <= l_rd;
            cur_slot <= l_slot;
          end
          MDS_MUL: begin
            cnt <= cnt + 1'b1;
            if (res_fire) state <= pend_v ? MDS_PEND : MDS_IDLE;
          end
          MDS_DIV: if (res_fire) state <= pend_v ? MDS_PEND : MDS_IDLE;
          default: state <= MDS_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed per-cycle vectors for muldiv_sched with a behavioural 3-cycle multiplier.
module tb_muldiv_sched;
  import muldiv_sched_pkg::*;

  logic        clk, rst, flush;
  logic [4:0]  req_op_0, req_rd_0, req_op_1, req_rd_1, md_op, res_rd;
  logic [31:0] req_s1_0, req_s2_0, req_s1_1, req_s2_1, md_a, md_b;
  logic [31:0] mul_result, div_result, res_data;
  logic        mul_start, div_start, div_done, div_kill, res_valid, res_slot, md_stall;

  muldiv_sched dut (
    .clk(clk), .rst(rst),
    .req_op_0(req_op_0), .req_s1_0(req_s1_0), .req_s2_0(req_s2_0), .req_rd_0(req_rd_0),
    .req_op_1(req_op_1), .req_s1_1(req_s1_1), .req_s2_1(req_s2_1), .req_rd_1(req_rd_1),
    .flush(flush), .mul_start(mul_start), .div_start(div_start), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .mul_result(mul_result), .div_done(div_done),
    .div_result(div_result), .div_kill(div_kill), .res_valid(res_valid),
    .res_data(res_data), .res_rd(res_rd), .res_slot(res_slot), .md_stall(md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product appears exactly 3 cycles after mul_start.
  logic [31:0] mp1 = '0, mp2 = '0, mp3 = '0;
  always @(posedge clk) begin
    mp1 <= mul_start ? md_a * md_b : 32'd0;
    mp2 <= mp1;
    mp3 <= mp2;
  end
  assign mul_result = mp3;

  typedef struct packed {
    logic rst, flush;
    logic [4:0] op0; logic [31:0] a0, b0; logic [4:0] rd0;
    logic [4:0] op1; logic [31:0] a1, b1; logic [4:0] rd1;
    logic dd; logic [31:0] dr;
  } in_t;

  typedef struct packed {
    logic ms, ds; logic [4:0] op; logic [31:0] a, b;
    logic rv; logic [31:0] data; logic [4:0] rd; logic slot; logic stall, kill;
  } out_t;

  typedef struct { in_t i; out_t o; string nm; } vec_t;

  vec_t tbl[$];
  int nvec = 0, nerr = 0;

  function automatic in_t i_nop(); in_t i = '0; return i; endfunction
  function automatic in_t i_req(logic [4:0] o0, logic [31:0] a0, logic [31:0] b0, logic [4:0] r0,
                                logic [4:0] o1, logic [31:0] a1, logic [31:0] b1, logic [4:0] r1);
    in_t i = '0;
    i.op0 = o0; i.a0 = a0; i.b0 = b0; i.rd0 = r0;
    i.op1 = o1; i.a1 = a1; i.b1 = b1; i.rd1 = r1;
    return i;
  endfunction
  function automatic in_t i_div(logic [31:0] r); in_t i = '0; i.dd = 1'b1; i.dr = r; return i; endfunction
  function automatic in_t i_fl(); in_t i = '0; i.flush = 1'b1; return i; endfunction

  function automatic out_t o_z(); out_t o = '0; return o; endfunction
  function automatic out_t o_st(); out_t o = '0; o.stall = 1'b1; return o; endfunction
  function automatic out_t o_k(); out_t o = '0; o.kill = 1'b1; return o; endfunction
  function automatic out_t o_go(bit m, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    out_t o = '0;
    o.ms = m; o.ds = !m; o.op = op; o.a = a; o.b = b; o.stall = 1'b1;
    return o;
  endfunction
  function automatic out_t o_res(logic [31:0] d, logic [4:0] rd, bit sl, bit st);
    out_t o = '0;
    o.rv = 1'b1; o.data = d; o.rd = rd; o.slot = sl; o.stall = st;
    return o;
  endfunction

  function automatic out_t cur_out();
    out_t o;
    o.ms = mul_start; o.ds = div_start; o.op = md_op; o.a = md_a; o.b = md_b;
    o.rv = res_valid; o.data = res_data; o.rd = res_rd; o.slot = res_slot;
    o.stall = md_stall; o.kill = div_kill;
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("ms=%0b ds=%0b op=%0d a=%0d b=%0d rv=%0b data=%0d rd=%0d slot=%0b stall=%0b kill=%0b",
                     o.ms, o.ds, o.op, o.a, o.b, o.rv, o.data, o.rd, o.slot, o.stall, o.kill);
  endfunction

  task automatic add(input in_t i, input out_t o, input string nm);
    vec_t v;
    v.i = i; v.o = o; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rst = i.rst; flush = i.flush;
    req_op_0 = i.op0; req_s1_0 = i.a0; req_s2_0 = i.b0; req_rd_0 = i.rd0;
    req_op_1 = i.op1; req_s1_1 = i.a1; req_s2_1 = i.b1; req_rd_1 = i.rd1;
    div_done = i.dd; div_result = i.dr;
  endtask

  task automatic check(input out_t e, input string nm);
    out_t a;
    a = cur_out();
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %s | want %s", nm, fmt(a), fmt(e));
    end
  endtask

  // One cycle: drive just after the rising edge, sample at the falling edge.
  task automatic step(input in_t i, input out_t e, input string nm);
    @(posedge clk); #1;
    drive(i);
    @(negedge clk);
    check(e, nm);
  endtask

  initial begin
    in_t t;
    t = i_req(ALU_MUL, 2, 2, 1, ALU_NOP, 0, 0, 0);
    drive(t);
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check(o_k(), "reset state");
    @(posedge clk); #1;
    drive(i_nop());

    // Single MUL, slot 1 non-md
    add(i_req(ALU_MUL, 7, 6, 3, ALU_ADD, 1, 2, 4), o_go(1, ALU_MUL, 7, 6), "A launch");
    add(i_nop(), o_st(), "A wait1");
    add(i_nop(), o_st(), "A wait2");
    add(i_nop(), o_res(42, 3, 0, 0), "A result");
    add(i_nop(), o_z(), "A idle");
    add(i_div(32'hdead), o_z(), "spurious div_done idle");
    // Paired MUL+MUL, with ignored requests and div_done mid-flight
    add(i_req(ALU_MUL, 3, 4, 5, ALU_MUL, 5, 5, 6), o_go(1, ALU_MUL, 3, 4), "B launch0");
    add(i_req(ALU_MUL, 9, 9, 7, ALU_MULH, 1, 1, 8), o_st(), "B req ignored");
    add(i_div(32'hbeef), o_st(), "B div_done ignored");
    add(i_nop(), o_res(12, 5, 0, 1), "B result0");
    add(i_nop(), o_go(1, ALU_MUL, 5, 5), "B launch1");
    add(i_nop(), o_st(), "B wait1");
    add(i_nop(), o_st(), "B wait2");
    add(i_nop(), o_res(25, 6, 1, 0), "B result1");
    // Slot-1-only DIV, done after 10 cycles
    add(i_req(ALU_NOP, 0, 0, 0, ALU_DIV, 100, 7, 9), o_go(0, ALU_DIV, 100, 7), "C launch");
    for (int k = 1; k < 10; k++) add(i_nop(), o_st(), "C wait");
    add(i_div(14), o_res(14, 9, 1, 0), "C result");
    add(i_nop(), o_z(), "C idle");
    // Paired DIV then MUL through PEND
    add(i_req(ALU_REM, 17, 5, 10, ALU_MUL, 2, 3, 11), o_go(0, ALU_REM, 17, 5), "D launch0");
    add(i_nop(), o_st(), "D wait");
    add(i_div(2), o_res(2, 10, 0, 1), "D result0");
    add(i_nop(), o_go(1, ALU_MUL, 2, 3), "D launch1");
    add(i_nop(), o_st(), "D wait1");
    add(i_nop(), o_st(), "D wait2");
    add(i_nop(), o_res(6, 11, 1, 0), "D result1");
    foreach (tbl[k]) step(tbl[k].i, tbl[k].o, tbl[k].nm);

    // Flush during DIV with slot-1 MUL pending
    step(i_req(ALU_DIV, 50, 5, 1, ALU_MUL, 2, 9, 2), o_go(0, ALU_DIV, 50, 5), "F launch");
    step(i_nop(), o_st(), "F wait");
    begin out_t o; o = o_st(); o.kill = 1'b1; step(i_fl(), o, "F flush kill"); end
    step(i_req(ALU_MUL, 4, 5, 12, ALU_NOP, 0, 0, 0), o_go(1, ALU_MUL, 4, 5), "F new accept");
    step(i_div(10), o_st(), "F late div_done");
    step(i_nop(), o_st(), "F wait2");
    step(i_nop(), o_res(20, 12, 0, 0), "F result no pend");
    step(i_nop(), o_z(), "F idle");

    // Flush in the first result cycle of a pair: result dropped, pend discarded
    step(i_req(ALU_MUL, 1, 1, 1, ALU_MUL, 2, 2, 2), o_go(1, ALU_MUL, 1, 1), "G launch");
    step(i_nop(), o_st(), "G wait1");
    step(i_nop(), o_st(), "G wait2");
    step(i_fl(), o_st(), "G flush result");
    step(i_nop(), o_z(), "G no pend launch");

    // Flush while the pending op is a DIV
    step(i_req(ALU_MUL, 3, 3, 13, ALU_DIVU, 9, 3, 14), o_go(1, ALU_MUL, 3, 3), "H launch");
    step(i_nop(), o_st(), "H wait1");
    step(i_nop(), o_st(), "H wait2");
    step(i_nop(), o_res(9, 13, 0, 1), "H result0");
    begin out_t o; o = o_st(); o.kill = 1'b1; step(i_fl(), o, "H flush pend div"); end
    step(i_nop(), o_z(), "H idle");

    // Flush in IDLE suppresses the launch
    t = i_req(ALU_MULHSU, 2, 2, 1, ALU_DIVU, 4, 2, 2); t.flush = 1'b1;
    step(t, o_z(), "I flush idle");
    step(i_nop(), o_z(), "I idle");

    // Reset at MUL cnt=2 with pend valid
    step(i_req(ALU_MUL, 3, 3, 1, ALU_MUL, 4, 4, 2), o_go(1, ALU_MUL, 3, 3), "R launch");
    step(i_nop(), o_st(), "R wait1");
    t = i_req(ALU_MUL, 6, 6, 3, ALU_DIV, 8, 2, 4); t.rst = 1'b1;
    step(t, o_k(), "R rst mid-mul");
    step(t, o_k(), "R rst held");
    @(posedge clk); #1;
    drive(i_nop());
    step(i_req(ALU_MUL, 8, 8, 7, ALU_NOP, 0, 0, 0), o_go(1, ALU_MUL, 8, 8), "R new launch");
    step(i_nop(), o_st(), "R wait2");
    step(i_nop(), o_st(), "R wait3");
    step(i_nop(), o_res(64, 7, 0, 0), "R result");
    step(i_nop(), o_z(), "R idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
